bus_scheduler: RTL and testbench
================================

# bus_scheduler

Round-robin transaction scheduler that shares the single UART byte link of the serial bus between `N_REQ` on-chip requesters. It arbitrates, serialises one command byte plus CRC-8 through the UART transmitter, collects the slave's response byte plus CRC-8 from the UART receiver, and returns data with connection and CRC status to the granted requester. It sits between the bus master front-end (Avalon slave side) and the UART TX/RX cores.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `TIMEOUT`, 50000: clock cycles allowed between response bytes before a connection error.

- `clock`  in  1: sole clock, all logic rising-edge.
- `reset`  in  1: synchronous, active-high reset.
- `req`  in  N_REQ: level request per requester, held until its `ack`.
- `req_cmd`  in  8*N_REQ: command byte of requester i at bits [8i+7:8i].
- `ack`  out  N_REQ: one-cycle completion pulse to the served requester.
- `rsp_data`  out  8: response byte, valid in the `ack` cycle, held until next `ack`.
- `con_error`  out  1: timeout flag, valid with `ack`, held until next `ack`.
- `crc_error`  out  1: response CRC mismatch flag, valid with `ack`, held until next `ack`.
- `tx_start`  out  1: one-cycle pulse launching `tx_data` on the UART TX.
- `tx_data`  out  8: byte to transmit, stable from `tx_start` until TX idle.
- `tx_busy`  in  1: UART TX busy; rises the cycle after `tx_start`.
- `rx_valid`  in  1: one-cycle pulse, received byte on `rx_data`.
- `rx_data`  in  8: received byte.

## Operation
- States: IDLE, SEND_CMD, WAIT_CMD, SEND_CRC, WAIT_CRC, RX_DATA, RX_CRC, DONE.
- IDLE: if any `req`, pick first set bit searching from `last+1` upward with wrap; latch index and its `req_cmd`; go SEND_CMD. `last` resets to N_REQ-1 (requester 0 wins first).
- SEND_CMD: when `tx_busy`=0, pulse `tx_start` with command byte, go WAIT_CMD. WAIT_CMD ignores `tx_busy` in its first cycle, then waits `tx_busy`=0, go SEND_CRC.
- SEND_CRC/WAIT_CRC: same handshake with CRC-8 of the command byte; then RX_DATA.
- CRC-8: poly 0x07, init 0x00, MSB first, no reflection, no final XOR (crc(0x01)=0x07, crc(0x02)=0x0E, crc(0x03)=0x09).
- RX_DATA: on `rx_valid` capture data byte, go RX_CRC. RX_CRC: on `rx_valid` compare with crc(data); mismatch sets `crc_error`; go DONE.
- Timeout counter clears on entry to RX_DATA and on every `rx_valid`; if it reaches TIMEOUT with no `rx_valid`, go DONE with `con_error`=1, `crc_error`=0, `rsp_data`=0x00.
- DONE: pulse `ack[idx]`, update `last`=idx, return IDLE.
- `rx_valid` outside RX_DATA/RX_CRC is discarded.
- Requester dropping `req` mid-transaction: transaction still completes and `ack` still pulses.
- Reset mid-transaction: immediate return to IDLE, no `ack`, no further `tx_start`.
- Reset values: `ack`=0, `tx_start`=0, `tx_data`=0x00, `rsp_data`=0x00, `con_error`=0, `crc_error`=0, state IDLE.

## Timing
- Grant: `req` sampled high in IDLE -> SEND_CMD next cycle; `tx_start` earliest 1 cycle later (2 cycles after `req`).
- `ack` pulses exactly 2 cycles after the accepted final `rx_valid` (RX_CRC->DONE, DONE drives `ack`); outputs registered.
- Back-to-back: next grant evaluated in the IDLE cycle following DONE; minimum 1 idle cycle between transactions.
- Timeout: `ack` with `con_error` asserts TIMEOUT+2 cycles after the last RX-state entry or `rx_valid`.
- `tx_start` never asserts while `tx_busy`=1.

## Configuration
- `BUS_SCHED_CRC_EN` defined: behaviour as above.
- Undefined: SEND_CRC, WAIT_CRC, RX_CRC removed; one command byte sent, first `rx_valid` in RX_DATA goes directly to DONE; `crc_error` constant 0.

## Test plan
- Single request: `req`=0001, cmd 0x01; TX model sees 0x01 then 0x07; respond 0x02, 0x0E -> `ack`=0001, `rsp_data`=0x02, both errors 0.
- Round-robin: `req`=1111 held, every response good -> `ack` order 0,1,2,3,0; `req`=0101 after grant 0 -> next grant 2.
- CRC fault: response 0x03 then 0x00 -> `ack`, `rsp_data`=0x03, `crc_error`=1, `con_error`=0.
- Timeout (TIMEOUT=100): send data byte, withhold CRC -> `ack` 102 cycles later, `con_error`=1, `rsp_data`=0x00.
- Reset mid-TX and stray `rx_valid` in IDLE: no `ack`, all outputs at reset values, next request from requester 0 served normally.
- Macro undefined: cmd 0x55 -> exactly one `tx_start`; one response byte 0xAA -> `ack`, `rsp_data`=0xAA, `crc_error`=0.

Source files
------------

// File: rtl/bus_scheduler.sv
// Round-robin scheduler sharing one UART byte link between N_REQ requesters.
// Define BUS_SCHED_CRC_EN to append a CRC-8 byte to the command and check one on the response.
module bus_scheduler #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_cmd,
    output logic [N_REQ-1:0]   ack,
    output logic [7:0]         rsp_data,
    output logic               con_error,
    output logic               crc_error,
    output logic               tx_start,
    output logic [7:0]         tx_data,
    input  logic               tx_busy,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND_CMD,
        WAIT_CMD,
`ifdef BUS_SCHED_CRC_EN
        SEND_CRC,
        WAIT_CRC,
        RX_CRC,
`endif
        RX_DATA,
        DONE
    } state_e;

`ifdef BUS_SCHED_CRC_EN
    function automatic logic [7:0] crc8(input logic [7:0] d);
        logic [7:0] c;
        c = d;
        for (int unsigned i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction
`endif

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [7:0]         cmd_q, cmd_d;
    logic               first_q, first_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         data_q, data_d;
    logic               tout_q, tout_d;
`ifdef BUS_SCHED_CRC_EN
    logic               crc_bad_q, crc_bad_d;
`endif

    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [7:0]         rsp_data_q, rsp_data_d;
    logic               con_error_q, con_error_d;
    logic               crc_error_q, crc_error_d;
    logic               tx_start_q, tx_start_d;
    logic [7:0]         tx_data_q, tx_data_d;

    logic               gnt_found;
    logic [IDX_W-1:0]   gnt_idx;
    logic [IDX_W:0]     cand;

    assign ack       = ack_q;
    assign rsp_data  = rsp_data_q;
    assign con_error = con_error_q;
    assign crc_error = crc_error_q;
    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;

    // Search starts just after the last served requester and wraps modulo N_REQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = last_q;
        cand      = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand = {1'b0, last_q} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(N_REQ)) begin
                cand = cand - (IDX_W+1)'(N_REQ);
            end
            if (!gnt_found && req[cand[IDX_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            last_q      <= IDX_W'(N_REQ - 1);
            cmd_q       <= '0;
            first_q     <= 1'b0;
            cnt_q       <= '0;
            data_q      <= '0;
            tout_q      <= 1'b0;
`ifdef BUS_SCHED_CRC_EN
            crc_bad_q   <= 1'b0;
`endif
            ack_q       <= '0;
            rsp_data_q  <= '0;
            con_error_q <= 1'b0;
            crc_error_q <= 1'b0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
            cmd_q       <= cmd_d;
            first_q     <= first_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            tout_q      <= tout_d;
`ifdef BUS_SCHED_CRC_EN
            crc_bad_q   <= crc_bad_d;
`endif
            ack_q       <= ack_d;
            rsp_data_q  <= rsp_data_d;
            con_error_q <= con_error_d;
            crc_error_q <= crc_error_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
        end
    end

    // The timeout counter holds cycles elapsed since RX entry (0) or since the last rx_valid cycle (1 next cycle).
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        last_d    = last_q;
        cmd_d     = cmd_q;
        first_d   = 1'b0;
        cnt_d     = cnt_q;
        data_d    = data_q;
        tout_d    = tout_q;
`ifdef BUS_SCHED_CRC_EN
        crc_bad_d = crc_bad_q;
`endif
        case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    idx_d   = gnt_idx;
                    cmd_d   = req_cmd[{gnt_idx, 3'b000} +: 8];
                    state_d = SEND_CMD;
                end
            end
            SEND_CMD: begin
                if (!tx_busy) begin
                    state_d = WAIT_CMD;
                    first_d = 1'b1;
                end
            end
            WAIT_CMD: begin
                if (!first_q && !tx_busy) begin
`ifdef BUS_SCHED_CRC_EN
                    state_d = SEND_CRC;
`else
                    state_d = RX_DATA;
                    cnt_d   = '0;
                    tout_d  = 1'b0;
                    data_d  = '0;
`endif
                end
            end
`ifdef BUS_SCHED_CRC_EN
            SEND_CRC: begin
                if (!tx_busy) begin
                    state_d = WAIT_CRC;
                    first_d = 1'b1;
                end
            end
            WAIT_CRC: begin
                if (!first_q && !tx_busy) begin
                    state_d   = RX_DATA;
                    cnt_d     = '0;
                    tout_d    = 1'b0;
                    data_d    = '0;
                    crc_bad_d = 1'b0;
                end
            end
            RX_CRC: begin
                if (rx_valid) begin
                    crc_bad_d = (rx_data != crc8(data_q));
                    state_d   = DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    tout_d    = 1'b1;
                    data_d    = '0;
                    crc_bad_d = 1'b0;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            RX_DATA: begin
                if (rx_valid) begin
                    data_d = rx_data;
                    cnt_d  = CNT_W'(1);
`ifdef BUS_SCHED_CRC_EN
                    state_d = RX_CRC;
`else
                    state_d = DONE;
`endif
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    tout_d  = 1'b1;
                    data_d  = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                last_d  = idx_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ack_d       = '0;
        rsp_data_d  = rsp_data_q;
        con_error_d = con_error_q;
        crc_error_d = crc_error_q;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        case (state_q)
            SEND_CMD: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = cmd_q;
                end
            end
`ifdef BUS_SCHED_CRC_EN
            SEND_CRC: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = crc8(cmd_q);
                end
            end
`endif
            DONE: begin
                ack_d       = N_REQ'(1) << idx_q;
                rsp_data_d  = data_q;
                con_error_d = tout_q;
`ifdef BUS_SCHED_CRC_EN
                crc_error_d = crc_bad_q;
`else
                crc_error_d = 1'b0;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bus_scheduler.sv
// Self-checking bench for bus_scheduler: vector table, timeout/reset sequences and randomized traffic
// against a UART TX/RX model and a round-robin/CRC reference model.
module tb_bus_scheduler;

    localparam int T = 100;
`ifdef BUS_SCHED_CRC_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif
    localparam int NTX = CRC_EN ? 2 : 1;
    localparam logic [31:0] CMDS = {8'h80, 8'h02, 8'h03, 8'h01};

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_cmd;
    logic [3:0]  ack;
    logic [7:0]  rsp_data;
    logic        con_error;
    logic        crc_error;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        rx_valid;
    logic [7:0]  rx_data;

    bus_scheduler #(.N_REQ(4), .TIMEOUT(T)) dut (
        .clock(clock), .reset(reset), .req(req), .req_cmd(req_cmd),
        .ack(ack), .rsp_data(rsp_data), .con_error(con_error), .crc_error(crc_error),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .rx_valid(rx_valid), .rx_data(rx_data)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] tx_q[$];
    bit pend = 1'b0;
    int left = 0;
    int busy_len = 2;
    int last_g;

    typedef struct {
        logic [3:0] req;
        bit         drop;
        logic [7:0] d;
        logic [7:0] c;
        logic [7:0] tx0;
        logic [7:0] tx1;
        logic [3:0] ack;
        logic [7:0] rsp;
        bit         crc_err;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_crc(input logic [7:0] d);
        logic [15:0] v;
        v = {d, 8'h00};
        for (int b = 15; b >= 8; b--) begin
            if (v[b]) v = v ^ (16'h0107 << (b - 8));
        end
        return v[7:0];
    endfunction

    function automatic int model_grant(input logic [3:0] m, input int lg);
        for (int k = 1; k <= 4; k++) begin
            if (m[(lg + k) % 4]) return (lg + k) % 4;
        end
        return -1;
    endfunction

    // One clock: sample outputs 1ns after the edge, then advance the UART TX model.
    task automatic tick();
        bit prev_busy;
        @(posedge clock);
        #1;
        prev_busy = tx_busy;
        if (prev_busy && tx_q.size() > 0) check("tx_data_stable", {24'h0, tx_data}, {24'h0, tx_q[$]});
        if (left > 0) begin
            left--;
            if (left == 0) tx_busy = 1'b0;
        end
        if (pend) begin
            pend    = 1'b0;
            tx_busy = 1'b1;
            left    = busy_len;
        end
        if (tx_start) begin
            check("tx_start_while_busy", {31'h0, prev_busy}, 32'h0);
            tx_q.push_back(tx_data);
            pend     = 1'b1;
            busy_len = $urandom_range(2, 5);
        end
    endtask

    task automatic run_txn(input logic [3:0] rq, input bit drop, input int nrsp,
                           input logic [7:0] d, input logic [7:0] c,
                           input logic [7:0] tx0, input logic [7:0] tx1,
                           input logic [3:0] eack, input logic [7:0] ersp,
                           input bit econ, input bit ecrc, input int elat, input string tag);
        int n;
        logic [8:0] got0, got1, exp1;
        tx_q.delete();
        req = rq;
        n = 0;
        do begin tick(); n++; end while (!tx_start && n < 50);
        check({tag, "_grant_lat"}, n, 2);
        if (drop) req = '0;
        n = 0;
        while (!(tx_q.size() == NTX && !pend && left == 0) && n < 200) begin tick(); n++; end
        got0 = (tx_q.size() > 0) ? {1'b0, tx_q[0]} : 9'h1FF;
        got1 = (tx_q.size() > 1) ? {1'b0, tx_q[1]} : 9'h1FF;
        exp1 = CRC_EN ? {1'b0, tx1} : 9'h1FF;
        check({tag, "_tx_cmd"}, {23'h0, got0}, {24'h0, tx0});
        check({tag, "_tx_crc"}, {23'h0, got1}, {23'h0, exp1});
        if (nrsp == 0) begin
            n = 0;
        end else begin
            tick();
            repeat ($urandom_range(0, 3)) tick();
            for (int k = 0; k < nrsp; k++) begin
                rx_valid = 1'b1;
                rx_data  = (k == 0) ? d : c;
                tick();
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
                if (k < nrsp - 1) repeat ($urandom_range(0, 3)) tick();
            end
            n = 1;
        end
        while (ack == '0 && n < elat + 20) begin tick(); n++; end
        check({tag, "_ack_lat"}, n, elat);
        check({tag, "_ack"}, {28'h0, ack}, {28'h0, eack});
        check({tag, "_rsp_data"}, {24'h0, rsp_data}, {24'h0, ersp});
        check({tag, "_con_error"}, {31'h0, con_error}, {31'h0, econ});
        check({tag, "_crc_error"}, {31'h0, crc_error}, {31'h0, ecrc});
        req = '0;
        tick();
        check({tag, "_ack_pulse"}, {28'h0, ack}, 32'h0);
        check({tag, "_rsp_hold"}, {24'h0, rsp_data}, {24'h0, ersp});
        check({tag, "_tx_count"}, tx_q.size(), NTX);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ack"}, {28'h0, ack}, 32'h0);
        check({tag, "_tx_start"}, {31'h0, tx_start}, 32'h0);
        check({tag, "_tx_data"}, {24'h0, tx_data}, 32'h0);
        check({tag, "_rsp_data"}, {24'h0, rsp_data}, 32'h0);
        check({tag, "_con_error"}, {31'h0, con_error}, 32'h0);
        check({tag, "_crc_error"}, {31'h0, crc_error}, 32'h0);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad;
        reset    = 1'b1;
        req      = '0;
        req_cmd  = CMDS;
        tx_busy  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = '0;

        tbl[0] = '{4'b0001, 1'b0, 8'h02, 8'h0E, 8'h01, 8'h07, 4'b0001, 8'h02, 1'b0};
        tbl[1] = '{4'b0010, 1'b0, 8'h03, 8'h00, 8'h03, 8'h09, 4'b0010, 8'h03, 1'b1};
        tbl[2] = '{4'b1111, 1'b1, 8'h01, 8'h07, 8'h02, 8'h0E, 4'b0100, 8'h01, 1'b0};
        tbl[3] = '{4'b1111, 1'b0, 8'h80, 8'h89, 8'h80, 8'h89, 4'b1000, 8'h80, 1'b0};
        tbl[4] = '{4'b1111, 1'b0, 8'h03, 8'h09, 8'h01, 8'h07, 4'b0001, 8'h03, 1'b0};
        tbl[5] = '{4'b0101, 1'b0, 8'h02, 8'h0E, 8'h02, 8'h0E, 4'b0100, 8'h02, 1'b0};
        tbl[6] = '{4'b1001, 1'b0, 8'h55, 8'hAC, 8'h80, 8'h89, 4'b1000, 8'h55, 1'b0};
        tbl[7] = '{4'b1001, 1'b0, 8'h01, 8'h07, 8'h01, 8'h07, 4'b0001, 8'h01, 1'b0};

        repeat (3) tick();
        reset = 1'b0;
        check_reset_values("reset");

        for (int i = 0; i < 8; i++) begin
            run_txn(tbl[i].req, tbl[i].drop, NTX, tbl[i].d, tbl[i].c, tbl[i].tx0, tbl[i].tx1,
                    tbl[i].ack, tbl[i].rsp, 1'b0, tbl[i].crc_err & CRC_EN, 2, $sformatf("tbl%0d", i));
        end

        // Data byte then silence: with CRC the missing CRC byte times out; without, it completes.
        run_txn(4'b0100, 1'b0, 1, 8'h5A, 8'h00, 8'h02, 8'h0E, 4'b0100,
                CRC_EN ? 8'h00 : 8'h5A, CRC_EN, 1'b0, CRC_EN ? T + 2 : 2, "tmo_crc");
        run_txn(4'b0010, 1'b0, 0, 8'h00, 8'h00, 8'h03, 8'h09, 4'b0010,
                8'h00, 1'b1, 1'b0, T + 3, "tmo_none");

        // Reset while the command byte is on the wire, then stray rx_valid pulses in IDLE.
        tx_q.delete();
        req = 4'b0001;
        n = 0;
        do begin tick(); n++; end while (!tx_start && n < 50);
        check("rst_pre_grant_lat", n, 2);
        reset = 1'b1;
        tick();
        pend    = 1'b0;
        left    = 0;
        tx_busy = 1'b0;
        check_reset_values("rst_mid");
        reset = 1'b0;
        req   = '0;
        bad   = 0;
        for (int i = 0; i < 20; i++) begin
            rx_valid = (i % 5 == 2);
            rx_data  = 8'($urandom);
            tick();
            if (tx_start || ack != '0) bad++;
        end
        rx_valid = 1'b0;
        check("rst_quiet", bad, 0);
        check_reset_values("rst_after");
        run_txn(4'b1111, 1'b0, NTX, 8'h02, 8'h0E, 8'h01, 8'h07, 4'b0001, 8'h02,
                1'b0, 1'b0, 2, "rst_next");
        last_g = 0;

        for (int r = 0; r < 40; r++) begin
            logic [3:0]  m;
            logic [31:0] cmds;
            logic [7:0]  d, c, cb;
            int g;
            bit good;
            m       = 4'($urandom_range(1, 15));
            cmds    = $urandom;
            req_cmd = cmds;
            g       = model_grant(m, last_g);
            cb      = cmds[g*8 +: 8];
            d       = 8'($urandom);
            good    = ($urandom_range(0, 3) != 0);
            c       = model_crc(d) ^ (good ? 8'h00 : 8'(1 << $urandom_range(0, 7)));
            run_txn(m, 1'($urandom_range(0, 1)), NTX, d, c, cb, model_crc(cb), 4'(1 << g), d,
                    1'b0, CRC_EN && !good, 2, $sformatf("rnd%0d", r));
            last_g = g;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
